// File: rtl/f1_light_seq.sv
// f1_light_seq -- F1 start-light sequencer with reaction timer.
//
// A trigger starts the sequence: lights fill one per en tick, all lights stay
// on for HOLD_MIN plus a pseudo-random number of en ticks, then all lights go
// out. The clk cycles until react are counted and reported. A react before
// lights-out is a jump start.
//
// Ports:
//   clk_i         sole clock, rising edge
//   rst_ni        asynchronous active-low reset
//   en_i          step strobe from an external prescaler (one-cycle pulse)
//   trigger_i     start request, honoured only in IDLE / DONE
//   react_i       driver response
//   data_out_o    light pattern, bit 0 is the first light
//   cmd_seq_o     high while lights are filling
//   cmd_delay_o   high during the random all-on hold
//   busy_o        high in FILL, HOLD and TIMING
//   time_out_o    last reaction time in clk cycles (all ones on jump start)
//   time_valid_o  one-cycle pulse when time_out_o is updated
//   jump_start_o  sticky: react seen before lights out
module f1_light_seq #(
  parameter int N_LIGHTS = 8,
  parameter int HOLD_MIN = 2,
  parameter int HOLD_RW  = 3,
  parameter int TIME_W   = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                trigger_i,
  input  logic                react_i,
  output logic [N_LIGHTS-1:0] data_out_o,
  output logic                cmd_seq_o,
  output logic                cmd_delay_o,
  output logic                busy_o,
  output logic [TIME_W-1:0]   time_out_o,
  output logic                time_valid_o,
  output logic                jump_start_o
);

  // Wide enough for the largest hold load, HOLD_MIN + 2^HOLD_RW - 1.
  localparam int HC_W = $clog2(HOLD_MIN + (1 << HOLD_RW));

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_HOLD, S_TIMING, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [N_LIGHTS-1:0] data_q, data_d, data_shl;
  logic [HC_W-1:0]     hold_q, hold_d;
  logic [TIME_W-1:0]   timer_q, timer_d;
  logic [TIME_W-1:0]   tout_q, tout_d;
  logic                tv_q, tv_d;
  logic                js_q, js_d;
  logic [15:0]         lfsr_q, lfsr_d;

  // State register and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      hold_q  <= '0;
      timer_q <= '0;
      tout_q  <= '0;
      tv_q    <= 1'b0;
      js_q    <= 1'b0;
      lfsr_q  <= 16'hACE1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      timer_q <= timer_d;
      tout_q  <= tout_d;
      tv_q    <= tv_d;
      js_q    <= js_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign data_shl = {data_q[N_LIGHTS-2:0], 1'b1};

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    hold_d  = hold_q;
    timer_d = timer_q;
    tout_d  = tout_q;
    tv_d    = 1'b0;
    js_d    = js_q;
    // Fibonacci LFSR, taps 16,14,13,11; free-running in every state.
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (trigger_i) begin
          state_d = S_FILL;
          data_d  = N_LIGHTS'(1);
          js_d    = 1'b0;
        end
      end
      S_FILL, S_HOLD: begin
        // react beats a coincident en: it is a jump start either way.
        if (react_i) begin
          state_d = S_DONE;
          data_d  = '0;
          js_d    = 1'b1;
          tout_d  = '1;
          tv_d    = 1'b1;
        end else if (en_i) begin
          if (state_q == S_FILL) begin
            data_d = data_shl;
            if (&data_shl) begin
              state_d = S_HOLD;
              hold_d  = HC_W'(HOLD_MIN) + HC_W'(lfsr_q[HOLD_RW-1:0]);
            end
          end else if (hold_q == HC_W'(1)) begin
            state_d = S_TIMING;
            data_d  = '0;
            timer_d = '0;
          end else begin
            hold_d = hold_q - HC_W'(1);
          end
        end
      end
      S_TIMING: begin
        if (react_i) begin
          state_d = S_DONE;
          tout_d  = timer_q;
          tv_d    = 1'b1;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TIME_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    cmd_seq_o   = (state_q == S_FILL);
    cmd_delay_o = (state_q == S_HOLD);
    busy_o      = (state_q == S_FILL) || (state_q == S_HOLD) || (state_q == S_TIMING);
  end

  assign data_out_o   = data_q;
  assign time_out_o   = tout_q;
  assign time_valid_o = tv_q;
  assign jump_start_o = js_q;

endmodule
